// File: rtl/wide_alu_regif_pkg.sv
// Shared definitions for the wide ALU AXI4-Lite register interface:
// register offsets, region bases, response codes, CTRL bit positions
// and the address decode helper.
package wide_alu_regif_pkg;

    localparam logic [63:0] CTRL_OFF    = 64'h000;
    localparam logic [63:0] OPSEL_OFF   = 64'h004;
    localparam logic [63:0] DEACCEL_OFF = 64'h008;
    localparam logic [63:0] STATUS_OFF  = 64'h00C;
    localparam logic [63:0] OPA_BASE    = 64'h100;
    localparam logic [63:0] OPB_BASE    = 64'h200;
    localparam logic [63:0] RES_BASE    = 64'h300;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned CTRL_TRIGGER_BIT   = 0;
    localparam int unsigned CTRL_CLEAR_ERR_BIT = 1;

    typedef enum logic [2:0] {
        REG_NONE    = 3'd0,
        REG_CTRL    = 3'd1,
        REG_OPSEL   = 3'd2,
        REG_DEACCEL = 3'd3,
        REG_STATUS  = 3'd4,
        REG_OPA     = 3'd5,
        REG_OPB     = 3'd6,
        REG_RESULT  = 3'd7
    } region_e;

    typedef struct packed {
        region_e    region;
        logic [7:0] index;
    } dec_t;

    // Map a byte address onto a register region and a word index inside it.
    // The two byte-lane bits are dropped; every other bit takes part, so any
    // alias outside the mapped windows lands in REG_NONE.
    function automatic dec_t addr_decode(input logic [63:0] addr,
                                         input logic [63:0] n_words);
        dec_t        d;
        logic [63:0] a;
        a        = {addr[63:2], 2'b00};
        d.region = REG_NONE;
        d.index  = 8'd0;
        if (a == CTRL_OFF) begin
            d.region = REG_CTRL;
        end else if (a == OPSEL_OFF) begin
            d.region = REG_OPSEL;
        end else if (a == DEACCEL_OFF) begin
            d.region = REG_DEACCEL;
        end else if (a == STATUS_OFF) begin
            d.region = REG_STATUS;
        end else if ((a >= OPA_BASE) && (a < (OPA_BASE + (n_words << 2)))) begin
            d.region = REG_OPA;
            d.index  = 8'((a - OPA_BASE) >> 2);
        end else if ((a >= OPB_BASE) && (a < (OPB_BASE + (n_words << 2)))) begin
            d.region = REG_OPB;
            d.index  = 8'((a - OPB_BASE) >> 2);
        end else if ((a >= RES_BASE) && (a < (RES_BASE + (n_words << 3)))) begin
            d.region = REG_RESULT;
            d.index  = 8'((a - RES_BASE) >> 2);
        end else begin
            d.region = REG_NONE;
        end
        return d;
    endfunction

    // Merge a 32-bit write into an existing word, byte lane by byte lane.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                r[8*b +: 8] = data[8*b +: 8];
            end else begin
                r[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wide_alu_axil_regif.sv
// AXI4-Lite slave exposing the operand, control and result registers of a
// wide ALU. AW and W are captured into independent one-entry holders, a
// write commits once both are full and the B channel is free. Reads are
// answered from registered R data with one-per-cycle throughput.
module wide_alu_axil_regif
    import wide_alu_regif_pkg::*;
#(
    parameter int unsigned ALU_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // AW channel
    input  logic [ADDR_WIDTH-1:0]  s_awaddr_i,
    input  logic                   s_awvalid_i,
    output logic                   s_awready_o,
    // W channel
    input  logic [31:0]            s_wdata_i,
    input  logic [3:0]             s_wstrb_i,
    input  logic                   s_wvalid_i,
    output logic                   s_wready_o,
    // B channel
    output logic [1:0]             s_bresp_o,
    output logic                   s_bvalid_o,
    input  logic                   s_bready_i,
    // AR channel
    input  logic [ADDR_WIDTH-1:0]  s_araddr_i,
    input  logic                   s_arvalid_i,
    output logic                   s_arready_o,
    // R channel
    output logic [31:0]            s_rdata_o,
    output logic [1:0]             s_rresp_o,
    output logic                   s_rvalid_o,
    input  logic                   s_rready_i,
    // ALU side
    output logic [ALU_WIDTH-1:0]   op_a_o,
    output logic [ALU_WIDTH-1:0]   op_b_o,
    output logic [2:0]             op_sel_o,
    output logic [3:0]             deaccel_o,
    output logic                   trigger_o,
    output logic                   clear_err_o,
    input  logic [2*ALU_WIDTH-1:0] result_i,
    input  logic [1:0]             status_i
);

    localparam int unsigned NWORDS   = ALU_WIDTH / 32;
    localparam logic [63:0] NWORDS64 = 64'(NWORDS);

    // Storage and response registers
    logic                  rdy_q,       rdy_d;
    logic                  aw_full_q,   aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q,   aw_addr_d;
    logic                  w_full_q,    w_full_d;
    logic [31:0]           w_data_q,    w_data_d;
    logic [3:0]            w_strb_q,    w_strb_d;
    logic                  bvalid_q,    bvalid_d;
    logic [1:0]            bresp_q,     bresp_d;
    logic                  rvalid_q,    rvalid_d;
    logic [1:0]            rresp_q,     rresp_d;
    logic [31:0]           rdata_q,     rdata_d;
    logic [ALU_WIDTH-1:0]  op_a_q,      op_a_d;
    logic [ALU_WIDTH-1:0]  op_b_q,      op_b_d;
    logic [2:0]            op_sel_q,    op_sel_d;
    logic [3:0]            deaccel_q,   deaccel_d;
    logic                  trigger_q,   trigger_d;
    logic                  clear_err_q, clear_err_d;

    // Combinational helpers
    dec_t        wdec_s;
    dec_t        rdec_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        ar_hs_s;
    logic        commit_s;
    logic [31:0] rd_data_s;
    logic [1:0]  rd_resp_s;

    // Readies are gated by rdy_q so they stay low throughout reset and rise
    // on the first clock after release. AR may be taken in the same cycle the
    // outstanding R beat is consumed.
    assign s_awready_o = rdy_q & ~aw_full_q;
    assign s_wready_o  = rdy_q & ~w_full_q;
    assign s_arready_o = rdy_q & (~rvalid_q | s_rready_i);

    assign aw_hs_s  = s_awvalid_i & s_awready_o;
    assign w_hs_s   = s_wvalid_i & s_wready_o;
    assign ar_hs_s  = s_arvalid_i & s_arready_o;
    assign commit_s = aw_full_q & w_full_q & ~bvalid_q;

    assign s_bresp_o   = bresp_q;
    assign s_bvalid_o  = bvalid_q;
    assign s_rdata_o   = rdata_q;
    assign s_rresp_o   = rresp_q;
    assign s_rvalid_o  = rvalid_q;
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign op_sel_o    = op_sel_q;
    assign deaccel_o   = deaccel_q;
    assign trigger_o   = trigger_q;
    assign clear_err_o = clear_err_q;

    // Decode the held write address and the presented read address.
    always_comb begin
        wdec_s = addr_decode(64'(aw_addr_q), NWORDS64);
        rdec_s = addr_decode(64'(s_araddr_i), NWORDS64);
    end

    // AW/W holders: filled on handshake, both emptied together on commit.
    always_comb begin
        rdy_d     = 1'b1;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (commit_s) begin
            aw_full_d = 1'b0;
        end else if (aw_hs_s) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_awaddr_i;
        end else begin
            aw_full_d = aw_full_q;
        end
        if (commit_s) begin
            w_full_d = 1'b0;
        end else if (w_hs_s) begin
            w_full_d = 1'b1;
            w_data_d = s_wdata_i;
            w_strb_d = s_wstrb_i;
        end else begin
            w_full_d = w_full_q;
        end
    end

    // Write commit: update the addressed register, raise B, fire CTRL pulses.
    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sel_d    = op_sel_q;
        deaccel_d   = deaccel_q;
        trigger_d   = 1'b0;
        clear_err_d = 1'b0;
        bresp_d     = bresp_q;
        bvalid_d    = bvalid_q;
        if (commit_s) begin
            bvalid_d = 1'b1;
            case (wdec_s.region)
                REG_CTRL: begin
                    bresp_d     = RESP_OKAY;
                    trigger_d   = w_strb_q[0] & w_data_q[CTRL_TRIGGER_BIT];
                    clear_err_d = w_strb_q[0] & w_data_q[CTRL_CLEAR_ERR_BIT];
                end
                REG_OPSEL: begin
                    bresp_d  = RESP_OKAY;
                    op_sel_d = w_strb_q[0] ? w_data_q[2:0] : op_sel_q;
                end
                REG_DEACCEL: begin
                    bresp_d   = RESP_OKAY;
                    deaccel_d = w_strb_q[0] ? w_data_q[3:0] : deaccel_q;
                end
                REG_OPA: begin
                    bresp_d = RESP_OKAY;
                    for (int i = 0; i < NWORDS; i++) begin
                        if (wdec_s.index == 8'(i)) begin
                            op_a_d[32*i +: 32] = apply_strb(op_a_q[32*i +: 32], w_data_q, w_strb_q);
                        end else begin
                            op_a_d[32*i +: 32] = op_a_q[32*i +: 32];
                        end
                    end
                end
                REG_OPB: begin
                    bresp_d = RESP_OKAY;
                    for (int i = 0; i < NWORDS; i++) begin
                        if (wdec_s.index == 8'(i)) begin
                            op_b_d[32*i +: 32] = apply_strb(op_b_q[32*i +: 32], w_data_q, w_strb_q);
                        end else begin
                            op_b_d[32*i +: 32] = op_b_q[32*i +: 32];
                        end
                    end
                end
                // Read-only or unmapped targets: error, nothing changes.
                default: begin
                    bresp_d = RESP_SLVERR;
                end
            endcase
        end else if (bvalid_q && s_bready_i) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
    end

    // Read mux: storage is read before any same-cycle commit lands, and
    // RESULT/STATUS are taken live from the ALU at the AR handshake.
    always_comb begin
        rd_data_s = 32'd0;
        rd_resp_s = RESP_OKAY;
        case (rdec_s.region)
            REG_CTRL:    rd_data_s = 32'd0;
            REG_OPSEL:   rd_data_s = {29'd0, op_sel_q};
            REG_DEACCEL: rd_data_s = {28'd0, deaccel_q};
            REG_STATUS:  rd_data_s = {30'd0, status_i};
            REG_OPA: begin
                for (int i = 0; i < NWORDS; i++) begin
                    if (rdec_s.index == 8'(i)) begin
                        rd_data_s = op_a_q[32*i +: 32];
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
            REG_OPB: begin
                for (int i = 0; i < NWORDS; i++) begin
                    if (rdec_s.index == 8'(i)) begin
                        rd_data_s = op_b_q[32*i +: 32];
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
            REG_RESULT: begin
                for (int i = 0; i < 2*NWORDS; i++) begin
                    if (rdec_s.index == 8'(i)) begin
                        rd_data_s = result_i[32*i +: 32];
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
            default: begin
                rd_data_s = 32'd0;
                rd_resp_s = RESP_SLVERR;
            end
        endcase
    end

    // R channel: capture on AR handshake, hold until the master takes it.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_s;
            rresp_d  = rd_resp_s;
        end else if (s_rready_i) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // State registers; reset drops everything including half-received writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q       <= 1'b0;
            aw_full_q   <= 1'b0;
            aw_addr_q   <= '0;
            w_full_q    <= 1'b0;
            w_data_q    <= 32'd0;
            w_strb_q    <= 4'd0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_q     <= 32'd0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sel_q    <= 3'd0;
            deaccel_q   <= 4'd0;
            trigger_q   <= 1'b0;
            clear_err_q <= 1'b0;
        end else begin
            rdy_q       <= rdy_d;
            aw_full_q   <= aw_full_d;
            aw_addr_q   <= aw_addr_d;
            w_full_q    <= w_full_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sel_q    <= op_sel_d;
            deaccel_q   <= deaccel_d;
            trigger_q   <= trigger_d;
            clear_err_q <= clear_err_d;
        end
    end

endmodule

// File: doc/wide_alu_axil_regif.md
WIDE_ALU_AXIL_REGIF -- requirements
Module: wide_alu_axil_regif

Interface
REQ-001 SHALL have parameter ALU_WIDTH, default 256: operand width in bits, multiple of 32, range 32..1024.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: AXI4-Lite address width, at least 10.
REQ-003 clk_i  input  1  clock, all logic on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 AW channel: s_awaddr_i (ADDR_WIDTH) input, s_awvalid_i input 1, s_awready_o output 1.
REQ-006 W channel: s_wdata_i input 32, s_wstrb_i input 4, s_wvalid_i input 1, s_wready_o output 1.
REQ-007 B channel: s_bresp_o output 2, s_bvalid_o output 1, s_bready_i input 1.
REQ-008 AR channel: s_araddr_i (ADDR_WIDTH) input, s_arvalid_i input 1, s_arready_o output 1.
REQ-009 R channel: s_rdata_o output 32, s_rresp_o output 2, s_rvalid_o output 1, s_rready_i input 1.
REQ-010 ALU side outputs: op_a_o and op_b_o (ALU_WIDTH each), op_sel_o 3, deaccel_o 4, trigger_o 1, clear_err_o 1.
REQ-011 ALU side inputs: result_i (2*ALU_WIDTH), status_i 2.

Function
REQ-012 Register map (byte offsets, N = ALU_WIDTH/32):
- 0x000 CTRL, write-only: bit0 trigger, bit1 clear_err.
- 0x004 OP_SEL, read/write, bits [2:0].
- 0x008 DEACCEL, read/write, bits [3:0].
- 0x00C STATUS, read-only, bits [1:0] = status_i.
- 0x100+4i OP_A word i, read/write, i < N.
- 0x200+4i OP_B word i, read/write, i < N.
- 0x300+4i RESULT word i, read-only, i < 2N.
REQ-013 Address bits [1:0] SHALL be ignored; decode uses the full remaining address.
REQ-014 AW and W SHALL be accepted independently, each into a one-entry holding register; ready is high while that holder is empty.
REQ-015 A write SHALL commit in the cycle both holders are full and no B response is pending.
- B response is registered: s_bvalid_o rises the cycle after commit.
- Both holders free in the same cycle.
REQ-016 s_bvalid_o SHALL stay high with a stable s_bresp_o until s_bready_i is sampled high.
REQ-017 Writes SHALL honour s_wstrb_i per byte; an all-zero strobe returns OKAY with no register change.
REQ-018 A CTRL write with strobe byte 0 set SHALL pulse trigger_o and/or clear_err_o high for exactly one cycle, the cycle after commit; CTRL reads return 0.
REQ-019 s_arready_o SHALL be high when no R response is pending.
- On an AR handshake, s_rdata_o and s_rresp_o are registered and s_rvalid_o rises the next cycle.
- These stay held until s_rready_i is high.
REQ-020 Unmapped address, a write to a read-only register, or a read of CTRL-reserved space SHALL return SLVERR (2'b10) with no side effect; unmapped reads return data 0.
REQ-021 OKAY SHALL be 2'b00.
REQ-022 A read and a write committing in the same cycle to the same register SHALL return the pre-write value.
REQ-023 RESULT and STATUS SHALL be sampled from result_i/status_i at the AR handshake cycle.
REQ-024 op_a_o, op_b_o, op_sel_o and deaccel_o SHALL be driven directly from storage registers (zero combinational path).
REQ-025 A back-to-back AR SHALL be accepted in the same cycle the previous R handshake completes, giving one read per cycle throughput.

Reset
REQ-026 On rst_ni low, all storage SHALL clear to 0 and every valid/pulse output SHALL be 0.
REQ-027 On rst_ni low, s_awready_o, s_wready_o and s_arready_o SHALL be 0 during reset and go to 1 the first cycle after deassertion.
REQ-028 Reset mid-transaction SHALL drop all held AW/W/AR state and pending responses, with no write commit.

Structure
REQ-029 Package wide_alu_regif_pkg SHALL hold the register offsets, region bases (0x100/0x200/0x300), the response codes and the CTRL bit positions.
REQ-030 No sub-module SHALL be used; decode is a package function, addr_decode, returning region and index.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Write 0xDEADBEEF to 0x104 with wstrb 0xF, then read 0x104 -> OKAY; rdata 0xDEADBEEF; op_a_o[63:32] = 0xDEADBEEF.
- W presented 3 cycles before AW, write 0x5 to 0x004 -> single B OKAY after AW; op_sel_o = 3'b101.
- Write 0x1 to 0x000 -> trigger_o high exactly 1 cycle; clear_err_o stays 0.
- Write to 0x300, and read 0x0F0 -> both SLVERR; no register changes; rdata 0.
- bready held low 5 cycles -> bvalid and bresp stable; awready/wready accept one more write into the holders, which commits only after B completes.
- Assert reset with AW held but W not yet sent -> after reset, the op registers read 0 and no B is issued.
